cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Parametrised run controller for the five-stage cache CPU. It sequences the core's reset and boot PC, gates execution, counts cycles and retired instructions, and detects program end (EBREAK/ECALL/self-loop), a cycle-budget timeout, or a retire hang. It sits between the top-level clock/reset and the `cpu` core, replacing a fixed 128-cycle free run with a controlled run/stop/status block usable in both simulation and FPGA bring-up.

## Interface
- `XLEN`, 32, PC/data width
- `BOOT_PC`, 32'h0, value driven on `boot_pc` during core reset
- `RST_CYCLES`, 4, cycles `cpu_rst` is held after `start` (≥1)
- `MAX_CYCLES`, 128, RUN-cycle budget before timeout (≥1, must fit in `CNT_W`)
- `STALL_LIMIT`, 16, consecutive RUN cycles without retire that flag a hang (≥1)
- `CNT_W`, 32, width of the cycle and instret counters

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to (re)start a run
- `retire_valid`  in  1  core retired one instruction this cycle
- `retire_pc`  in  XLEN  PC of the retiring instruction
- `retire_instr`  in  32  encoding of the retiring instruction
- `cpu_rst`  out  1  reset to core
- `cpu_en`  out  1  core advance enable (pipeline freeze when 0)
- `boot_pc`  out  XLEN  constant `BOOT_PC`
- `busy`  out  1  in RESET or RUN
- `done`  out  1  halted on a halt instruction
- `timeout`  out  1  cycle budget exhausted
- `hang`  out  1  stall watchdog fired
- `cycle_cnt`  out  CNT_W  RUN cycles of current/last run
- `instret_cnt`  out  CNT_W  instructions retired in current/last run
- `last_pc`  out  XLEN  PC of last retired instruction

## Operation
- States: IDLE, RESET, RUN, HALT, TMO.
- IDLE: `cpu_rst`=1, `cpu_en`=0. `start` → RESET.
- RESET: `cpu_rst`=1 for exactly `RST_CYCLES` cycles; counters, `last_pc`, flags cleared on entry; then → RUN.
- RUN: `cpu_rst`=0, `cpu_en`=1; `cycle_cnt`+1 every cycle; `instret_cnt`+1 and `last_pc`←`retire_pc` on `retire_valid`.
- Halt: `retire_valid` with `retire_instr` ∈ {32'h00100073 EBREAK, 32'h00000073 ECALL, 32'h0000006F `jal x0,0`} → HALT, `done`=1. The halting instruction is counted.
- Timeout: RUN cycle in which `cycle_cnt` reaches `MAX_CYCLES`−1 (i.e. the `MAX_CYCLES`-th RUN cycle) without a halt → TMO, `timeout`=1.
- Hang: `STALL_LIMIT` consecutive RUN cycles with `retire_valid`=0 → TMO, `hang`=1, `timeout`=0.
- HALT/TMO: `cpu_rst`=0, `cpu_en`=0 (core state preserved for inspection); counters frozen; `start` → RESET (flags cleared).
- `start` in RESET or RUN ignored.
- Priority in one RUN cycle: halt > hang > timeout.
- Counters saturate at all-ones; no wrap.
- `retire_*` ignored outside RUN.

## Timing
- Reset values: state IDLE, `cpu_rst`=1, `cpu_en`=0, `busy`=0, `done`/`timeout`/`hang`=0, counters 0, `last_pc`=0; `boot_pc`=`BOOT_PC` always.
- All outputs registered or decoded from registered state; no input-to-output combinational path.
- `start` at edge N → `busy`=1 after N; `cpu_en`=1 first after edge N+`RST_CYCLES`.
- Halt retire at edge M → `done`=1, `cpu_en`=0 after M; counters include cycle M.
- Asserting `rst` mid-run: immediate return to IDLE values, core put back in reset.

## Structure
- Package `run_ctrl_pkg`: state enum, halt encodings (`INSTR_EBREAK`, `INSTR_ECALL`, `INSTR_SELF_LOOP`), `is_halt_instr()` function.
- Sub-module `stall_watchdog` (params `LIMIT`; in `clk`, `rst`, `clr`, `tick`, `kick`; out `fire`): consecutive-idle counter, cleared on RESET entry and on each retire.
- Reset-length counter and cycle/instret counters live in `cpu_run_ctrl`.

## Test plan
- Reset then `start`, retire every cycle from PC 0 by +4, EBREAK at instret 10 → `done`=1, `instret_cnt`=10, `last_pc`=36, `cpu_en`=0 next cycle.
- No halt, retire every cycle, `MAX_CYCLES`=128 → `timeout`=1 after 128 RUN cycles, `cycle_cnt`=128, `hang`=0.
- Retire stops after 5 instructions, `STALL_LIMIT`=16 → `hang`=1 exactly 16 cycles after last retire, `instret_cnt`=5.
- EBREAK retired on the 128th RUN cycle → `done`=1, `timeout`=0 (priority).
- `start` during RUN ignored; `start` in HALT → `cpu_rst` high for `RST_CYCLES`=4, counters and flags 0, new run proceeds.
- `rst` asserted mid-RUN asynchronously → outputs at reset values before next edge; `start` afterwards runs normally.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : run_ctrl_pkg
// Purpose  : Shared run-controller state encoding and halt-instruction decode.
// Revision : 1.0
// ============================================================================
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_HALT  = 3'd3,
        ST_TMO   = 3'd4
    } run_state_e;

    localparam logic [31:0] INSTR_EBREAK    = 32'h0010_0073;
    localparam logic [31:0] INSTR_ECALL     = 32'h0000_0073;
    localparam logic [31:0] INSTR_SELF_LOOP = 32'h0000_006F;

    function automatic logic is_halt_instr(input logic [31:0] instr);
        return (instr == INSTR_EBREAK) || (instr == INSTR_ECALL) ||
               (instr == INSTR_SELF_LOOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stall_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : stall_watchdog
// Purpose  : Counts consecutive ticks without a kick; fires on the LIMIT-th one.
// Revision : 1.0
// ============================================================================
module stall_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    input  logic kick,
    output logic fire
);

    localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] idle_q;
    logic [CW-1:0] idle_d;

    // fire is combinational so the controller can leave RUN on the same edge
    always_comb begin
        idle_d = idle_q;
        fire   = 1'b0;
        if (clr) begin
            idle_d = '0;
        end else if (tick) begin
            if (kick) begin
                idle_d = '0;
            end else if (idle_q == LAST) begin
                fire = 1'b1;
            end else begin
                idle_d = idle_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Core reset sequencing, run gating, cycle/instret counting and
//            end-of-program, cycle-budget and retire-hang detection.
// Revision : 1.0
// ============================================================================
module cpu_run_ctrl #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] BOOT_PC     = '0,
    parameter int              RST_CYCLES  = 4,
    parameter int              MAX_CYCLES  = 128,
    parameter int              STALL_LIMIT = 16,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic [31:0]      retire_instr,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic [XLEN-1:0]  boot_pc,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             hang,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [XLEN-1:0]  last_pc
);

    import run_ctrl_pkg::*;

    localparam int               RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

    run_state_e       state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             hang_q, hang_d;
    logic             wd_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    stall_watchdog #(
        .LIMIT (STALL_LIMIT)
    ) u_watchdog (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_RESET),
        .tick (state_q == ST_RUN),
        .kick (retire_valid),
        .fire (wd_fire)
    );

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        last_pc_d = last_pc_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        hang_d    = hang_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_TMO: begin
                if (start) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = '0;
                    cycle_d   = '0;
                    instret_d = '0;
                    last_pc_d = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    hang_d    = 1'b0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            ST_RUN: begin
                cycle_d = sat_inc(cycle_q);
                if (retire_valid) begin
                    instret_d = sat_inc(instret_q);
                    last_pc_d = retire_pc;
                end
                // halt beats hang beats timeout when they coincide
                if (retire_valid && is_halt_instr(retire_instr)) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                end else if (wd_fire) begin
                    state_d = ST_TMO;
                    hang_d  = 1'b1;
                end else if (cycle_q == CYC_LAST) begin
                    state_d   = ST_TMO;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rst_cnt_q <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            last_pc_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            hang_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            last_pc_q <= last_pc_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            hang_q    <= hang_d;
        end
    end

    assign cpu_rst     = (state_q == ST_IDLE) || (state_q == ST_RESET);
    assign cpu_en      = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RESET) || (state_q == ST_RUN);
    assign boot_pc     = BOOT_PC;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign hang        = hang_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign last_pc     = last_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Purpose  : Self-checking bench for cpu_run_ctrl against a run-outcome model.
// Revision : 1.0
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int          RST_CYCLES  = 4;
    localparam int          MAX_CYCLES  = 128;
    localparam int          STALL_LIMIT = 16;
    localparam logic [31:0] BOOT        = 32'h0000_0080;
    localparam logic [31:0] EBREAK      = 32'h0010_0073;
    localparam logic [31:0] ECALL       = 32'h0000_0073;
    localparam logic [31:0] SELF_LOOP   = 32'h0000_006F;
    localparam int          WHY_DONE = 1, WHY_HANG = 2, WHY_TMO = 3;

    logic        clk, rst, start, retire_valid;
    logic [31:0] retire_pc, retire_instr;
    logic        cpu_rst, cpu_en, busy, done, timeout, hang;
    logic [31:0] boot_pc, cycle_cnt, instret_cnt, last_pc;

    int total;
    int bad;

    // per-RUN-cycle stimulus of one run
    logic        sv  [0:MAX_CYCLES-1];
    logic [31:0] spc [0:MAX_CYCLES-1];
    logic [31:0] si  [0:MAX_CYCLES-1];

    // model results: index of final RUN cycle, reason, instret, last pc
    int          m_last, m_why, m_instret;
    logic [31:0] m_pc;

    cpu_run_ctrl #(
        .XLEN        (32),
        .BOOT_PC     (BOOT),
        .RST_CYCLES  (RST_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_instr (retire_instr),
        .cpu_rst      (cpu_rst),
        .cpu_en       (cpu_en),
        .boot_pc      (boot_pc),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .hang         (hang),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt),
        .last_pc      (last_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] plain_instr();
        return ($urandom & 32'hFFFF_FF80) | 32'h0000_0013;
    endfunction

    function automatic logic halting(input logic [31:0] x);
        return (x == EBREAK) || (x == ECALL) || (x == SELF_LOOP);
    endfunction

    // Outcome of a run straight from the rules: walk the retire stream and stop
    // at the first halt, the STALL_LIMIT-th idle in a row, or the budget end.
    function automatic void model_run();
        int idle_run;
        idle_run  = 0;
        m_instret = 0;
        m_pc      = 32'h0;
        m_why     = 0;
        m_last    = MAX_CYCLES - 1;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            if (sv[i]) begin
                m_instret = m_instret + 1;
                m_pc      = spc[i];
                idle_run  = 0;
                if (halting(si[i])) begin
                    m_last = i; m_why = WHY_DONE; return;
                end
            end else begin
                idle_run = idle_run + 1;
                if (idle_run == STALL_LIMIT) begin
                    m_last = i; m_why = WHY_HANG; return;
                end
            end
            if (i == MAX_CYCLES - 1) begin
                m_last = i; m_why = WHY_TMO; return;
            end
        end
    endfunction

    // start pulse, then RST_CYCLES reset cycles fed with retire noise
    task automatic launch();
        start        = 1'b1;
        retire_valid = 1'b1;
        retire_instr = EBREAK;
        retire_pc    = $urandom;
        tick();
        start = 1'b0;
        repeat (RST_CYCLES) tick();
        retire_valid = 1'b0;
    endtask

    // drives RUN cycles 0..last; early counts cycles where the core was not enabled
    task automatic drive_run(input int last, input int start_at, output int early);
        early = 0;
        for (int i = 0; i <= last; i++) begin
            if (cpu_en !== 1'b1) early++;
            retire_valid = sv[i];
            retire_pc    = spc[i];
            retire_instr = si[i];
            start        = (i == start_at);
            tick();
        end
        start        = 1'b0;
        retire_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; retire_valid = 1'b0; retire_pc = '0; retire_instr = '0;
        #1;
        total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({done, timeout, hang} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {done, timeout, hang}); end
        total++; if ({cycle_cnt, instret_cnt, last_pc} !== 96'h0) begin bad++; $display("FAIL reset_counts: got %h want 0", {cycle_cnt, instret_cnt, last_pc}); end
        total++; if (boot_pc !== BOOT) begin bad++; $display("FAIL boot_pc: got %h want %h", boot_pc, BOOT); end
        repeat (2) tick();
        rst = 1'b0;
        retire_valid = 1'b1; retire_instr = EBREAK; retire_pc = 32'h44;
        repeat (2) tick();
        retire_valid = 1'b0;
        total++; if ({busy, cpu_rst, cpu_en} !== 3'b010) begin bad++; $display("FAIL idle_ctrl: got %b want 010", {busy, cpu_rst, cpu_en}); end
        total++; if ({instret_cnt, last_pc, done} !== 65'h0) begin bad++; $display("FAIL idle_ignores_retire: got %h want 0", {instret_cnt, last_pc, done}); end
    endtask

    task automatic test_halt();
        int          early;
        logic [31:0] c0;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            sv[i] = 1'b1; spc[i] = 32'(4 * i); si[i] = (i == 9) ? EBREAK : plain_instr();
        end
        model_run();
        launch();
        drive_run(m_last, -1, early);
        total++; if (early != 0) begin bad++; $display("FAIL halt_run_gap: got %0d want 0", early); end
        total++; if ({done, timeout, hang} !== 3'b100) begin bad++; $display("FAIL halt_flags: got %b want 100", {done, timeout, hang}); end
        total++; if (instret_cnt !== 32'd10) begin bad++; $display("FAIL halt_instret: got %0d want 10", instret_cnt); end
        total++; if (last_pc !== 32'd36) begin bad++; $display("FAIL halt_last_pc: got %0d want 36", last_pc); end
        total++; if (cycle_cnt !== 32'(m_last + 1)) begin bad++; $display("FAIL halt_cycles: got %0d want %0d", cycle_cnt, m_last + 1); end
        total++; if ({cpu_en, cpu_rst, busy} !== 3'b000) begin bad++; $display("FAIL halt_ctrl: got %b want 000", {cpu_en, cpu_rst, busy}); end
        c0 = cycle_cnt;
        retire_valid = 1'b1; retire_pc = 32'h999; retire_instr = plain_instr();
        repeat (3) tick();
        retire_valid = 1'b0;
        total++; if ({cycle_cnt, instret_cnt, last_pc} !== {c0, 32'd10, 32'd36}) begin bad++; $display("FAIL halt_frozen: got %h want %h", {cycle_cnt, instret_cnt, last_pc}, {c0, 32'd10, 32'd36}); end
    endtask

    task automatic test_timeout();
        int early;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            sv[i] = 1'b1; spc[i] = $urandom; si[i] = plain_instr();
        end
        model_run();
        launch();
        drive_run(m_last, -1, early);
        total++; if (early != 0) begin bad++; $display("FAIL tmo_run_gap: got %0d want 0", early); end
        total++; if ({done, timeout, hang} !== 3'b010) begin bad++; $display("FAIL tmo_flags: got %b want 010", {done, timeout, hang}); end
        total++; if (cycle_cnt !== 32'd128) begin bad++; $display("FAIL tmo_cycles: got %0d want 128", cycle_cnt); end
        total++; if ({instret_cnt, last_pc} !== {32'(m_instret), m_pc}) begin bad++; $display("FAIL tmo_retire: got %h want %h", {instret_cnt, last_pc}, {32'(m_instret), m_pc}); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL tmo_cpu_en: got %b want 0", cpu_en); end
    endtask

    task automatic test_hang();
        int early;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            sv[i] = (i < 5); spc[i] = 32'h200 + 32'(4 * i); si[i] = plain_instr();
        end
        model_run();
        launch();
        drive_run(m_last, -1, early);
        total++; if (early != 0) begin bad++; $display("FAIL hang_early: got %0d want 0", early); end
        total++; if ({done, timeout, hang} !== 3'b001) begin bad++; $display("FAIL hang_flags: got %b want 001", {done, timeout, hang}); end
        total++; if (instret_cnt !== 32'd5) begin bad++; $display("FAIL hang_instret: got %0d want 5", instret_cnt); end
        total++; if (cycle_cnt !== 32'(m_last + 1)) begin bad++; $display("FAIL hang_cycles: got %0d want %0d", cycle_cnt, m_last + 1); end
        total++; if ({cpu_en, last_pc} !== {1'b0, 32'h210}) begin bad++; $display("FAIL hang_stop: got %h want %h", {cpu_en, last_pc}, {1'b0, 32'h210}); end
    endtask

    task automatic test_priority();
        int early;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            sv[i] = 1'b1; spc[i] = 32'(8 * i); si[i] = (i == MAX_CYCLES - 1) ? EBREAK : plain_instr();
        end
        model_run();
        launch();
        drive_run(m_last, -1, early);
        total++; if (early != 0) begin bad++; $display("FAIL prio_early: got %0d want 0", early); end
        total++; if ({done, timeout, hang} !== 3'b100) begin bad++; $display("FAIL prio_flags: got %b want 100", {done, timeout, hang}); end
        total++; if ({cycle_cnt, instret_cnt} !== {32'd128, 32'd128}) begin bad++; $display("FAIL prio_counts: got %h want %h", {cycle_cnt, instret_cnt}, {32'd128, 32'd128}); end
    endtask

    task automatic test_back_to_back();
        int early;
        int rst_hi;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            sv[i] = 1'b1; spc[i] = 32'h100 + 32'(4 * i); si[i] = (i == 7) ? ECALL : plain_instr();
        end
        launch();
        drive_run(7, 3, early);
        total++; if (early != 0) begin bad++; $display("FAIL run_start_ignored: got %0d gaps want 0", early); end
        total++; if ({done, instret_cnt} !== {1'b1, 32'd8}) begin bad++; $display("FAIL b2b_first_run: got %h want %h", {done, instret_cnt}, {1'b1, 32'd8}); end
        start = 1'b1;
        tick();
        start  = 1'b0;
        rst_hi = 1;
        total++; if ({busy, done, cycle_cnt, instret_cnt, last_pc} !== 98'h2_0000_0000_0000_0000_0000_0000) begin
            bad++; $display("FAIL restart_cleared: got %h want %h", {busy, done, cycle_cnt, instret_cnt, last_pc}, 98'h2_0000_0000_0000_0000_0000_0000);
        end
        if (cpu_rst !== 1'b1) rst_hi = 0;
        for (int j = 1; j < RST_CYCLES; j++) begin
            tick();
            if (cpu_rst === 1'b1) rst_hi++;
        end
        tick();
        total++; if (rst_hi != RST_CYCLES) begin bad++; $display("FAIL restart_rst_len: got %0d want %0d", rst_hi, RST_CYCLES); end
        total++; if ({cpu_rst, cpu_en} !== 2'b01) begin bad++; $display("FAIL restart_enable: got %b want 01", {cpu_rst, cpu_en}); end
        for (int i = 0; i < MAX_CYCLES; i++) begin
            sv[i] = 1'b1; spc[i] = 32'(4 * i); si[i] = (i == 4) ? SELF_LOOP : plain_instr();
        end
        drive_run(4, -1, early);
        total++; if ({early, done, instret_cnt, last_pc} !== {32'd0, 1'b1, 32'd5, 32'd16}) begin
            bad++; $display("FAIL restart_second_run: got %h want %h", {early, done, instret_cnt, last_pc}, {32'd0, 1'b1, 32'd5, 32'd16});
        end
    endtask

    task automatic test_async_rst();
        int early;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            sv[i] = 1'b1; spc[i] = 32'h300 + 32'(4 * i); si[i] = plain_instr();
        end
        launch();
        drive_run(2, -1, early);
        #2;
        rst = 1'b1;
        #1;
        total++; if ({cpu_rst, cpu_en, busy} !== 3'b100) begin bad++; $display("FAIL async_ctrl: got %b want 100", {cpu_rst, cpu_en, busy}); end
        total++; if ({cycle_cnt, instret_cnt, last_pc} !== 96'h0) begin bad++; $display("FAIL async_counts: got %h want 0", {cycle_cnt, instret_cnt, last_pc}); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < MAX_CYCLES; i++) si[i] = (i == 6) ? SELF_LOOP : plain_instr();
        model_run();
        launch();
        drive_run(m_last, -1, early);
        total++; if ({early, done, instret_cnt, last_pc} !== {32'd0, 1'b1, 32'd7, 32'h318}) begin
            bad++; $display("FAIL async_rerun: got %h want %h", {early, done, instret_cnt, last_pc}, {32'd0, 1'b1, 32'd7, 32'h318});
        end
    endtask

    task automatic test_random();
        int early;
        int pct;
        for (int r = 0; r < 8; r++) begin
            pct = (r < 3) ? 20 : 95;
            for (int i = 0; i < MAX_CYCLES; i++) begin
                sv[i]  = ($urandom_range(99) < pct);
                spc[i] = $urandom;
                si[i]  = ($urandom_range(99) < 2) ? ((r % 2 == 0) ? ECALL : EBREAK) : plain_instr();
            end
            model_run();
            launch();
            drive_run(m_last, -1, early);
            total++; if (early != 0) begin bad++; $display("FAIL rnd%0d_early: got %0d want 0", r, early); end
            total++; if ({done, hang, timeout} !== {m_why == WHY_DONE, m_why == WHY_HANG, m_why == WHY_TMO}) begin
                bad++; $display("FAIL rnd%0d_flags: got %b want %b", r, {done, hang, timeout}, {m_why == WHY_DONE, m_why == WHY_HANG, m_why == WHY_TMO});
            end
            total++; if ({cycle_cnt, instret_cnt, last_pc} !== {32'(m_last + 1), 32'(m_instret), m_pc}) begin
                bad++; $display("FAIL rnd%0d_counts: got %h want %h", r, {cycle_cnt, instret_cnt, last_pc}, {32'(m_last + 1), 32'(m_instret), m_pc});
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_halt();
        test_timeout();
        test_hang();
        test_priority();
        test_back_to_back();
        test_async_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
